// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches instruction words from instruction memory
// one at a time, presents each to decode, and handles execute-stage redirects
// (including misaligned targets, which are steered to the trap vector).
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        stall,
   output logic        inst_valid,
   output logic [31:0] inst_code,
   output logic [31:0] inst_pc,
   output logic        misalign_err,
   output logic [31:0] inst_count
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            disc_q, disc_d;
   logic [XLEN-1:0] disc_tgt_q, disc_tgt_d;
   logic [XLEN-1:0] code_d, ipc_d, count_d;
   logic            err_d;
   logic            misaligned_c;
   logic [XLEN-1:0] redir_pc_c;

   // Effective redirect destination: misaligned targets go to the trap vector
   always_comb begin
      misaligned_c = (redirect_target[1:0] != 2'b00);
      redir_pc_c   = misaligned_c ? TRAP_VECTOR : redirect_target;
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, next-pc and next-output decisions
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      disc_d     = disc_q;
      disc_tgt_d = disc_tgt_q;
      code_d     = inst_code;
      ipc_d      = inst_pc;
      count_d    = inst_count;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Redirects are ignored here; start fetching at the reset vector
            state_d = ST_REQ;
            pc_d    = RESET_VECTOR;
            disc_d  = 1'b0;
         end
         ST_REQ: begin
            err_d = redirect & misaligned_c;
            if (imem_ack) begin
               if (redirect) begin
                  // Same-cycle redirect wins: drop the word, refetch at target
                  pc_d   = redir_pc_c;
                  disc_d = 1'b0;
               end else if (disc_q) begin
                  // Word belongs to a squashed path: drop it, go to latched target
                  pc_d   = disc_tgt_q;
                  disc_d = 1'b0;
               end else begin
                  code_d  = imem_rdata;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + XLEN'(4);
                  state_d = ST_OUT;
               end
            end else if (redirect) begin
               // Keep the request stable; remember where to go once it completes
               disc_d     = 1'b1;
               disc_tgt_d = redir_pc_c;
            end
         end
         ST_OUT: begin
            err_d = redirect & misaligned_c;
            if (redirect) begin
               pc_d    = redir_pc_c;
               state_d = ST_REQ;
            end else if (!stall) begin
               count_d = inst_count + XLEN'(1);
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = RESET_VECTOR;
            disc_d  = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs, aligned with the state they belong to
   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q         <= RESET_VECTOR;
         disc_q       <= 1'b0;
         disc_tgt_q   <= RESET_VECTOR;
         imem_req     <= 1'b0;
         imem_addr    <= RESET_VECTOR;
         inst_valid   <= 1'b0;
         inst_code    <= '0;
         inst_pc      <= '0;
         misalign_err <= 1'b0;
         inst_count   <= '0;
      end else begin
         pc_d_commit: begin
            pc_q       <= pc_d;
            disc_q     <= disc_d;
            disc_tgt_q <= disc_tgt_d;
         end
         imem_req     <= (state_d == ST_REQ);
         imem_addr    <= pc_d;
         inst_valid   <= (state_d == ST_OUT);
         inst_code    <= code_d;
         inst_pc      <= ipc_d;
         misalign_err <= err_d;
         inst_count   <= count_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        stall = 1'b0;
   logic        inst_valid;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;
   logic        misalign_err;
   logic [31:0] inst_count;

   int n_checks = 0;
   int n_errors = 0;

   pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_target(redirect_target),
      .stall(stall),
      .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc),
      .misalign_err(misalign_err), .inst_count(inst_count)
   );

   always #5 clock = ~clock;

   // Memory contents: a fixed, address-derived word
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Memory responder: acks every request, except it withholds ack for
   // delay_n cycles the first time delay_addr is requested
   logic [31:0] delay_addr = 32'hFFFF_FFFF;
   int          delay_n    = 0;
   int          waited     = 0;
   always @(negedge clock) begin
      if (imem_req === 1'b1 && imem_addr === delay_addr && waited < delay_n) begin
         imem_ack = 1'b0;
         waited   = waited + 1;
      end else begin
         imem_ack = 1'b1;
         if (imem_req !== 1'b1 || imem_addr !== delay_addr) waited = 0;
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks whether we are idle, fetching or holding an
   // instruction for decode, and what each output must be as a consequence
   typedef struct {
      logic        fetching;
      logic        holding;
      logic [31:0] pc;
      logic        squash;
      logic [31:0] squash_pc;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] code;
      logic [31:0] ipc;
      logic        err;
      logic [31:0] count;
   } mdl_t;

   function automatic mdl_t model_step(input mdl_t s, input logic rst_n, input logic ack,
                                       input logic redir, input logic [31:0] tgt, input logic stl);
      mdl_t n = s;
      logic [31:0] dest = (tgt[1:0] != 2'b00) ? TV : tgt;
      logic active = s.fetching | s.holding;
      if (!rst_n) begin
         n.fetching = 1'b0; n.holding = 1'b0; n.pc = RV; n.squash = 1'b0; n.squash_pc = RV;
         n.code = 32'h0; n.ipc = 32'h0; n.count = 32'h0; n.err = 1'b0;
         n.req = 1'b0; n.addr = RV; n.valid = 1'b0;
         return n;
      end
      n.err = redir && active && (tgt[1:0] != 2'b00);
      if (!active) begin
         n.fetching = 1'b1;
         n.pc = RV;
         n.squash = 1'b0;
      end else if (s.fetching) begin
         if (ack && redir) begin
            n.pc = dest; n.squash = 1'b0;
         end else if (ack && s.squash) begin
            n.pc = s.squash_pc; n.squash = 1'b0;
         end else if (ack) begin
            n.code = mem_word(s.pc); n.ipc = s.pc; n.pc = s.pc + 32'd4;
            n.fetching = 1'b0; n.holding = 1'b1;
         end else if (redir) begin
            n.squash = 1'b1; n.squash_pc = dest;
         end
      end else begin
         if (redir) begin
            n.pc = dest; n.holding = 1'b0; n.fetching = 1'b1;
         end else if (!stl) begin
            n.count = s.count + 32'd1; n.holding = 1'b0; n.fetching = 1'b1;
         end
      end
      n.req   = n.fetching;
      n.addr  = n.pc;
      n.valid = n.holding;
      return n;
   endfunction

   mdl_t m;
   logic chk_en = 1'b0;

   always @(posedge clock) begin
      m <= model_step(m, reset, imem_ack, redirect, redirect_target, stall);
      if (!reset) chk_en <= 1'b1;
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en) begin
         check32("cyc_imem_req",     {31'b0, imem_req},     {31'b0, m.req});
         check32("cyc_imem_addr",    imem_addr,             m.addr);
         check32("cyc_inst_valid",   {31'b0, inst_valid},   {31'b0, m.valid});
         check32("cyc_inst_code",    inst_code,             m.code);
         check32("cyc_inst_pc",      inst_pc,               m.ipc);
         check32("cyc_misalign_err", {31'b0, misalign_err}, {31'b0, m.err});
         check32("cyc_inst_count",   inst_count,            m.count);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic wait_req(input logic [31:0] a);
      int k = 0;
      while (!(imem_req === 1'b1 && imem_addr === a) && k < 60) begin
         tick();
         k++;
      end
      if (k >= 60) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_req timeout: addr %h expected %h", imem_addr, a);
      end
   endtask

   task automatic wait_valid(input logic [31:0] a);
      int k = 0;
      while (!(inst_valid === 1'b1 && inst_pc === a) && k < 60) begin
         tick();
         k++;
      end
      if (k >= 60) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_valid timeout: inst_pc %h expected %h", inst_pc, a);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) tick();
      check32("rst_imem_req",   {31'b0, imem_req},     32'h0);
      check32("rst_imem_addr",  imem_addr,             32'h0);
      check32("rst_inst_valid", {31'b0, inst_valid},   32'h0);
      check32("rst_inst_count", inst_count,            32'h0);
      check32("rst_misalign",   {31'b0, misalign_err}, 32'h0);

      // Straight-line fetch with ack tied high
      reset = 1'b1;
      tick(); check32("seq_req0", {31'b0, imem_req}, 32'h1); check32("seq_addr0", imem_addr, 32'h0);
      tick(); check32("seq_valid0", {31'b0, inst_valid}, 32'h1); check32("seq_pc0", inst_pc, 32'h0);
              check32("seq_code0", inst_code, 32'h0000_FFFF);
      tick(); check32("seq_addr4", imem_addr, 32'h4); check32("seq_cnt1", inst_count, 32'd1);
      tick(); check32("seq_pc4", inst_pc, 32'h4);
      tick(); check32("seq_addr8", imem_addr, 32'h8); check32("seq_cnt2", inst_count, 32'd2);
      tick(); check32("seq_pc8", inst_pc, 32'h8);
      tick(); check32("seq_cnt3", inst_count, 32'd3); check32("seq_addrc", imem_addr, 32'hC);

      // Ack withheld for 3 cycles at 0x8
      delay_addr = 32'h8; delay_n = 3;
      do_reset();
      wait_req(32'h8);
      check32("dly_addr_c0", imem_addr, 32'h8);
      for (int i = 1; i < 4; i++) begin
         tick();
         check32("dly_req_hold",  {31'b0, imem_req}, 32'h1);
         check32("dly_addr_hold", imem_addr, 32'h8);
      end
      tick(); check32("dly_valid8", {31'b0, inst_valid}, 32'h1); check32("dly_pc8", inst_pc, 32'h8);
      tick(); check32("dly_single_valid", {31'b0, inst_valid}, 32'h0);
      delay_n = 0;

      // Decode stall for 5 cycles while presenting 0x4
      do_reset();
      wait_valid(32'h4);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check32("stl_valid", {31'b0, inst_valid}, 32'h1);
         check32("stl_pc",    inst_pc,   32'h4);
         check32("stl_code",  inst_code, 32'h0004_FFFF);
         check32("stl_noreq", {31'b0, imem_req}, 32'h0);
         check32("stl_cnt",   inst_count, 32'd1);
      end
      stall = 1'b0;
      tick(); check32("stl_release_addr", imem_addr, 32'h8); check32("stl_release_cnt", inst_count, 32'd2);

      // Redirect to 0x40 while the fetch of 0x8 is still waiting
      delay_addr = 32'h8; delay_n = 2;
      do_reset();
      wait_req(32'h8);
      redirect = 1'b1; redirect_target = 32'h40;
      tick(); redirect = 1'b0;
      check32("sq_addr_held", imem_addr, 32'h8);
      tick(); check32("sq_addr_held2", imem_addr, 32'h8);
      tick(); check32("sq_new_addr", imem_addr, 32'h40); check32("sq_no_valid", {31'b0, inst_valid}, 32'h0);
      tick(); check32("sq_pc40", inst_pc, 32'h40); check32("sq_valid40", {31'b0, inst_valid}, 32'h1);
      delay_n = 0;

      // Two redirects while waiting: newer target wins; then redirect with ack
      delay_addr = 32'h4; delay_n = 3;
      do_reset();
      wait_req(32'h4);
      redirect = 1'b1; redirect_target = 32'h20;
      tick(); redirect_target = 32'h30;
      tick(); redirect = 1'b0;
      check32("rep_addr_held", imem_addr, 32'h4);
      tick();
      tick(); check32("rep_new_addr", imem_addr, 32'h30); check32("rep_no_valid", {31'b0, inst_valid}, 32'h0);
      redirect = 1'b1; redirect_target = 32'h13;
      tick(); redirect = 1'b0;
      check32("ack_redir_addr", imem_addr, TV); check32("ack_redir_err", {31'b0, misalign_err}, 32'h1);
      check32("ack_redir_novalid", {31'b0, inst_valid}, 32'h0);
      tick(); check32("ack_redir_err_clr", {31'b0, misalign_err}, 32'h0); check32("ack_redir_pc", inst_pc, TV);
      delay_n = 0;

      // Misaligned redirect while presenting 0x4
      do_reset();
      wait_valid(32'h4);
      redirect = 1'b1; redirect_target = 32'h42;
      tick(); redirect = 1'b0;
      check32("mis_err", {31'b0, misalign_err}, 32'h1);
      check32("mis_addr", imem_addr, 32'h100);
      check32("mis_novalid", {31'b0, inst_valid}, 32'h0);
      check32("mis_cnt", inst_count, 32'd1);
      tick(); check32("mis_err_clr", {31'b0, misalign_err}, 32'h0); check32("mis_pc", inst_pc, 32'h100);

      // PC wrap at the top of the address space, then reset mid-request
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick(); redirect = 1'b0;
      check32("wrap_addr_top", imem_addr, 32'hFFFF_FFFC); check32("wrap_cnt", inst_count, 32'd1);
      tick(); check32("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
      tick(); check32("wrap_addr0", imem_addr, 32'h0); check32("wrap_req", {31'b0, imem_req}, 32'h1);
      check32("wrap_cnt2", inst_count, 32'd2);
      reset = 1'b0;
      tick(); check32("mid_rst_req", {31'b0, imem_req}, 32'h0); check32("mid_rst_cnt", inst_count, 32'h0);
      check32("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
      tick();
      reset = 1'b1; redirect = 1'b1; redirect_target = 32'h43;
      tick(); redirect = 1'b0;
      check32("idle_redir_addr", imem_addr, 32'h0); check32("idle_redir_err", {31'b0, misalign_err}, 32'h0);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100: fetch address after a misaligned redirect.
REQ-003 The block SHALL use reset reset, synchronous, active-low, and clock clock.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  fetch address; word aligned.
REQ-008 imem_ack  in  1  memory accepts request; imem_rdata valid same cycle.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 redirect  in  1  taken branch/jump from execute, single-cycle pulse.
REQ-011 redirect_target  in  32  new PC for redirect.
REQ-012 stall  in  1  decode cannot accept the presented instruction.
REQ-013 inst_valid  out  1  inst_code/inst_pc valid toward decode.
REQ-014 inst_code  out  32  delivered instruction.
REQ-015 inst_pc  out  32  address of inst_code.
REQ-016 misalign_err  out  1  one-cycle pulse on misaligned redirect_target.
REQ-017 inst_count  out  32  count of instructions accepted by decode.

Function
REQ-018 FSM states SHALL be IDLE, REQ, OUT; outputs SHALL be registered.
REQ-019 IDLE: unconditional transition to REQ next cycle with pc = RESET_VECTOR.
REQ-020 REQ: imem_req=1, imem_addr=pc; both SHALL hold stable until imem_ack=1.
REQ-021 REQ with imem_ack=1 and no discard pending: capture imem_rdata into inst_code and pc into inst_pc, set pc=pc+4, go to OUT; inst_valid=1 the next cycle (1-cycle latency from ack).
REQ-022 OUT: inst_valid=1; with stall=1, inst_valid, inst_code and inst_pc SHALL hold unchanged; with stall=0, increment inst_count and go to REQ.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); inst_count SHALL wrap the same way.
REQ-024 Redirect in OUT: drop inst_valid the next cycle, do not count the instruction (even if stall=0), set pc=target, go to REQ.
REQ-025 Redirect in REQ without ack: latch target and a discard flag; keep imem_addr unchanged; on the subsequent ack drop the data and re-enter REQ at the latched target.
REQ-026 Redirect in the same cycle as ack: drop the data, set pc=target, stay in REQ with the new address next cycle.
REQ-027 Redirect while discard is already pending: the newer target SHALL replace the latched one.
REQ-028 redirect_target[1:0]!=0: misalign_err=1 for one cycle; TRAP_VECTOR SHALL be used in place of the target; all other redirect rules unchanged.
REQ-029 Redirect in IDLE: ignored.

Reset
REQ-030 While reset=0 at a clock edge: state=IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst_code=0, inst_pc=0, misalign_err=0, inst_count=0, and discard flag cleared.
REQ-031 A reset mid-transaction SHALL abandon any outstanding request without waiting for imem_ack; a late ack SHALL be ignored in IDLE.

Verification
REQ-032 Reset released, ack tied 1, stall 0 -> imem_addr sequence 0x0, 0x4, 0x8 on successive REQ cycles; inst_pc follows one cycle after each ack; inst_count=3 after third OUT.
REQ-033 Ack delayed 3 cycles at addr 0x8 -> imem_addr held at 0x8 with imem_req=1 for all 4 cycles; single inst_valid for 0x8.
REQ-034 stall=1 for 5 cycles in OUT with inst_pc=0x4 -> inst_valid, inst_code, inst_pc constant; no imem_req; inst_count unchanged until stall drops.
REQ-035 Redirect to 0x40 during REQ without ack, ack two cycles later -> that data never appears on inst_valid; next imem_addr=0x40.
REQ-036 Redirect to 0x42 in OUT -> misalign_err pulse; next imem_addr=TRAP_VECTOR (0x100); discarded instruction not counted.
REQ-037 pc=0xFFFF_FFFC fetched, stall 0 -> next imem_addr=0x0; reset asserted while imem_req=1 -> next cycle imem_req=0, inst_count=0.
